// File: rtl/rv32i_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
// Holds the frame-parser state encoding and the word geometry.
package rv32i_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_word_packer.sv
// Collects stream bytes into little-endian 32-bit words.
// Emits a one-cycle word_ready pulse the cycle after the last lane arrives.
module byte_word_packer
    import rv32i_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_lane_last,
    output logic        o_word_ready,
    output logic [31:0] o_word
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    logic [LANE_W-1:0]           r_byte_idx;
    logic [WORD_BYTES-2:0][7:0]  r_lanes;
    logic [31:0]                 r_word;
    logic                        r_word_ready;

    assign o_lane_last  = i_byte_en && (r_byte_idx == LAST_LANE);
    assign o_word_ready = r_word_ready;
    assign o_word       = r_word;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx   <= '0;
            r_lanes      <= '0;
            r_word       <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_clr) begin
                r_byte_idx <= '0;
            end else if (i_byte_en) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                if (r_byte_idx == LAST_LANE) begin
                    // The top lane goes straight into the output word, no extra cycle.
                    r_word       <= {i_byte, r_lanes};
                    r_word_ready <= 1'b1;
                end else begin
                    r_lanes[r_byte_idx] <= i_byte;
                end
            end
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses a count/words/XOR-checksum byte frame into instruction memory
// and keeps the core in reset until a verified image has been written.
module imem_stream_loader
    import rv32i_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_data,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_count;
    logic [7:0]        r_csum;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_write_addr;

    logic              w_accept;
    logic [15:0]       w_count_full;
    logic              w_count_bad;
    logic              w_last_word;
    logic              w_byte_en;
    logic              w_packer_clr;
    logic              w_lane_last;
    logic              w_word_ready;
    logic [31:0]       w_word;

    assign w_accept     = in_valid && in_ready;
    assign w_count_full = {in_data, r_count[7:0]};
    assign w_count_bad  = (w_count_full == 16'd0) || (w_count_full > 16'(MAX_WORDS));
    assign w_last_word  = (16'(r_word_idx) == (r_count - 16'd1));
    assign w_byte_en    = w_accept && (r_state == DATA);
    assign w_packer_clr = reload || ((r_state == CNT_HI) && w_accept);

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_packer_clr),
        .i_byte_en    (w_byte_en),
        .i_byte       (in_data),
        .o_lane_last  (w_lane_last),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    assign write_en   = w_word_ready;
    assign write_addr = r_write_addr;
    assign write_data = w_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CNT_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        core_rst     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;

        case (r_state)
            CNT_LO: begin
                in_ready = 1'b1;
                if (w_accept) w_next_state = CNT_HI;
            end
            CNT_HI: begin
                in_ready = 1'b1;
                if (w_accept) w_next_state = w_count_bad ? ERR : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                if (w_lane_last && w_last_word) w_next_state = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (w_accept) w_next_state = (in_data == r_csum) ? DONE : ERR;
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: w_next_state = CNT_LO;
        endcase

        // Reload wins over everything and blocks acceptance in its own cycle.
        if (reload) begin
            w_next_state = CNT_LO;
            in_ready     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_csum       <= '0;
            r_word_idx   <= '0;
            r_write_addr <= '0;
        end else if (reload) begin
            r_count    <= '0;
            r_csum     <= '0;
            r_word_idx <= '0;
        end else begin
            case (r_state)
                CNT_LO: if (w_accept) r_count[7:0] <= in_data;
                CNT_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= in_data;
                        r_csum        <= '0;
                        r_word_idx    <= '0;
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ in_data;
                        if (w_lane_last) begin
                            // Address is latched alongside the word so both appear with write_en.
                            r_write_addr <= r_word_idx;
                            r_word_idx   <= r_word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot loader that sits directly upstream of the core's instruction-memory write port (write_en / write_addr / write_data).
- Accepts a byte stream over a valid/ready handshake and parses a framed program image: a 16-bit word count, then the words, then an XOR checksum.
- Assembles little-endian 32-bit words and writes them into consecutive instruction-memory locations.
- Holds the core in reset until the image is loaded and verified.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted word count; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- reload  input  1  single-cycle pulse; aborts any operation and restarts frame reception.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte.
- write_en  output  1  instruction-memory write strobe, one cycle per word.
- write_addr  output  ADDR_W  instruction-memory word address.
- write_data  output  32  instruction word.
- core_rst  output  1  reset to the core; high until a valid image is loaded.
- done  output  1  image loaded and checksum matched.
- error  output  1  bad word count or checksum mismatch.

Behaviour:
- Reset values: state=CNT_LO, in_ready=1, write_en=0, write_addr=0, write_data=0, core_rst=1, done=0, error=0. The internal word count, byte index and checksum are all 0.
- A byte is accepted when in_valid && in_ready are both high on a rising edge.
- State CNT_LO: accepted byte → count[7:0]; go to CNT_HI.
- State CNT_HI: accepted byte → count[15:8]; then:
  - if count==0 or count>MAX_WORDS → ERR;
  - otherwise → DATA, with byte index=0, word index=0, checksum=0.
- State DATA: each accepted byte is XORed into the checksum and placed into lane byte_idx of the word buffer (lane 0 = bits 7:0, little-endian).
  - byte_idx advances 0→3 and wraps to 0.
  - On acceptance of lane 3: the next cycle has write_en=1, write_data = assembled word, write_addr = word index. The word index then increments. Latency is 1 cycle from the 4th byte to write_en.
  - write_en is high for exactly one cycle per word. write_addr holds its last value when write_en is 0.
  - in_ready stays 1 throughout DATA; back-to-back bytes are accepted every cycle. A write-in-progress never stalls input.
  - When lane 3 of word count-1 is accepted → CSUM.
- State CSUM: accepted byte is compared with the running checksum.
  - Equal → DONE: core_rst=0 and done=1 from the following cycle.
  - Unequal → ERR.
  - The final write_en pulse and the CSUM acceptance may occur in the same cycle.
- State DONE: in_ready=0, core_rst=0, done=1. Held until reload or rst.
- State ERR: in_ready=0, core_rst=1, error=1. Held until reload or rst.
- reload, in any state:
  - next state is CNT_LO; core_rst=1; done=0; error=0; counters and checksum cleared;
  - any write_en that would occur in the next cycle is suppressed;
  - in_ready is forced 0 during the reload cycle, so no byte is accepted in that cycle.
- rst asserted mid-frame: immediate asynchronous return to the reset values. Partially loaded memory contents are not cleared.
- Word counts wrap only within ADDR_W. MAX_WORDS = 2**ADDR_W is legal; the last address is 2**ADDR_W-1.

Decomposition:
- Shared package rv32i_loader_pkg contains:
  - the state enum (CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR);
  - constant WORD_BYTES=4.
- One natural sub-module, byte_word_packer: byte_idx counter, 4-lane shift/assembly register and word_ready pulse. The FSM, address counter and checksum stay in the top level.

Test Plan:
- Stream 02 00, 13 00 A0 00, 93 00 10 00, checksum 0x30 → two write_en pulses:
  - addr 0 data 0x00A00013;
  - addr 1 data 0x00100093;
  - then done=1, core_rst=0, in_ready=0.
- Same frame with checksum 0x31 → both writes occur, then error=1, core_rst=1, done=0.
- Count 00 00, and separately count 01 04 (0x401 > 1024) → ERR right after the hi byte; no write_en ever asserted.
- Frame sent with in_valid toggled every other cycle → identical writes and addresses. Each write_en lands exactly 1 cycle after the 4th byte of its word.
- reload pulsed after 6 data bytes, then a new 1-word frame 01 00, EF BE AD DE, checksum 0x22 → single write: addr 0 data 0xDEADBEEF, then done=1.
- rst asserted mid-DATA → all outputs return to reset values immediately (asynchronous), and a subsequent complete frame loads correctly.
